// File: rtl/sat_pkg.sv
// Shared definitions for the SAT solver datapath: clause occurrence database
// opcodes, controller states and default sizing.
package sat_pkg;

  localparam int DEF_CLAUSE_NUM = 7;
  localparam int DEF_VAR_NUM    = 7;

  typedef enum logic [1:0] {
    DB_READ  = 2'b00,
    DB_WRITE = 2'b01,
    DB_SET   = 2'b10,
    DB_CLR   = 2'b11
  } db_op_t;

  typedef enum logic {
    DB_INIT = 1'b0,
    DB_IDLE = 1'b1
  } db_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clause_occ_bank.sv
// Single-polarity occurrence bank: one CLAUSE_NUM-bit mask per variable, with
// whole-word write, single-bit set/clear and an index-driven clear port used by
// the controller's zeroing sweep. Reads are combinational.
module clause_occ_bank
  import sat_pkg::*;
#(
  parameter int CLAUSE_NUM = DEF_CLAUSE_NUM,
  parameter int VAR_NUM    = DEF_VAR_NUM,
  parameter int VAR_W      = clog2_min1(VAR_NUM),
  parameter int CL_W       = clog2_min1(CLAUSE_NUM)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  db_op_t                wr_op_i,
  input  logic [VAR_W-1:0]      wr_addr_i,
  input  logic [CLAUSE_NUM-1:0] wr_data_i,
  input  logic [CL_W-1:0]       wr_clause_i,
  input  logic                  clr_en_i,
  input  logic [VAR_W-1:0]      clr_idx_i,
  input  logic [VAR_W-1:0]      rd_addr_i,
  output logic [CLAUSE_NUM-1:0] rd_data_o
);

  logic [CLAUSE_NUM-1:0] mem_q [VAR_NUM];

  // Storage update: sweep clear wins, otherwise apply the validated edit.
  // NOTE: the array has no reset term; the controller's INIT sweep zeroes every
  // entry before requests are accepted, so a reset here would only add fan-out.
  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (wr_en_i) begin
      unique case (wr_op_i)
        DB_WRITE: mem_q[wr_addr_i]              <= wr_data_i;
        DB_SET:   mem_q[wr_addr_i][wr_clause_i] <= 1'b1;
        DB_CLR:   mem_q[wr_addr_i][wr_clause_i] <= 1'b0;
        default:  ;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/clause_occ_db.sv
// Dual-polarity clause occurrence memory for the BCP unit. A small controller
// zeroes both banks after reset or db_clear, then executes one request per
// cycle; READ data is registered onto the response port one cycle later.
module clause_occ_db
  import sat_pkg::*;
#(
  parameter int CLAUSE_NUM = DEF_CLAUSE_NUM,
  parameter int VAR_NUM    = DEF_VAR_NUM,
  parameter int VAR_W      = clog2_min1(VAR_NUM),
  parameter int CL_W       = clog2_min1(CLAUSE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  db_clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_pol,
  input  logic [VAR_W-1:0]      req_addr,
  input  logic [CLAUSE_NUM-1:0] req_wdata,
  input  logic [CL_W-1:0]       req_clause,
  output logic                  rsp_valid,
  output logic [CLAUSE_NUM-1:0] rsp_pos,
  output logic [CLAUSE_NUM-1:0] rsp_neg,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam logic [VAR_W:0]   VAR_LIM  = (VAR_W+1)'(VAR_NUM);
  localparam logic [CL_W:0]    CL_LIM   = (CL_W+1)'(CLAUSE_NUM);
  localparam logic [VAR_W-1:0] LAST_IDX = VAR_W'(VAR_NUM - 1);

  db_state_t             state_q, state_d;
  logic [VAR_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CLAUSE_NUM-1:0] rsp_pos_q, rsp_pos_d;
  logic [CLAUSE_NUM-1:0] rsp_neg_q, rsp_neg_d;
  logic                  rsp_err_q, rsp_err_d;

  db_op_t                op;
  logic                  accept;
  logic                  addr_ok;
  logic                  clause_ok;
  logic                  edit_en;
  logic                  sweep_en;
  logic [CLAUSE_NUM-1:0] pos_rd;
  logic [CLAUSE_NUM-1:0] neg_rd;

  assign op        = db_op_t'(req_op);
  assign init_done = (state_q == DB_IDLE);
  assign req_ready = init_done && !db_clear;
  assign accept    = req_valid && req_ready;
  assign addr_ok   = ({1'b0, req_addr} < VAR_LIM);
  assign clause_ok = ({1'b0, req_clause} < CL_LIM);
  assign sweep_en  = (state_q == DB_INIT);

  // An edit touches memory only if its address (and clause, for bit edits) is in range.
  assign edit_en = accept && (op != DB_READ) && addr_ok &&
                   ((op == DB_WRITE) || clause_ok);

  clause_occ_bank #(
    .CLAUSE_NUM (CLAUSE_NUM),
    .VAR_NUM    (VAR_NUM),
    .VAR_W      (VAR_W),
    .CL_W       (CL_W)
  ) u_pos_bank (
    .clk         (clk),
    .wr_en_i     (edit_en && !req_pol),
    .wr_op_i     (op),
    .wr_addr_i   (req_addr),
    .wr_data_i   (req_wdata),
    .wr_clause_i (req_clause),
    .clr_en_i    (sweep_en),
    .clr_idx_i   (cnt_q),
    .rd_addr_i   (req_addr),
    .rd_data_o   (pos_rd)
  );

  clause_occ_bank #(
    .CLAUSE_NUM (CLAUSE_NUM),
    .VAR_NUM    (VAR_NUM),
    .VAR_W      (VAR_W),
    .CL_W       (CL_W)
  ) u_neg_bank (
    .clk         (clk),
    .wr_en_i     (edit_en && req_pol),
    .wr_op_i     (op),
    .wr_addr_i   (req_addr),
    .wr_data_i   (req_wdata),
    .wr_clause_i (req_clause),
    .clr_en_i    (sweep_en),
    .clr_idx_i   (cnt_q),
    .rd_addr_i   (req_addr),
    .rd_data_o   (neg_rd)
  );

  // Controller: sweep indices 0..VAR_NUM-1 in INIT, db_clear restarts the sweep.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DB_INIT: begin
        if (db_clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_IDLE: begin
        if (db_clear) begin
          state_d = DB_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = DB_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response next-state: READ loads masks (or zero + err); otherwise hold the masks.
  always_comb begin
    rsp_valid_d = accept && (op == DB_READ);
    rsp_pos_d   = rsp_pos_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_d) begin
      if (addr_ok) begin
        rsp_pos_d = pos_rd;
        rsp_neg_d = neg_rd;
        rsp_err_d = 1'b0;
      end else begin
        rsp_pos_d = '0;
        rsp_neg_d = '0;
        rsp_err_d = 1'b1;
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_pos_q   <= '0;
      rsp_neg_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_pos_q   <= rsp_pos_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_pos   = rsp_pos_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_err   = rsp_err_q;

endmodule
